// File: rtl/voice_allocator_if.sv
// Note-event handshake between a MIDI event source and the voice allocator.
// The source holds an event on the bus until valid and ready meet.
interface voice_allocator_if;
   logic       inEventValid;
   logic       inEventNoteOn;
   logic [6:0] inEventNote;
   logic       outEventReady;

   modport master (
      output inEventValid,
      output inEventNoteOn,
      output inEventNote,
      input  outEventReady
   );

   modport slave (
      input  inEventValid,
      input  inEventNoteOn,
      input  inEventNote,
      output outEventReady
   );
endinterface

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: scans all voices per event, then commits a
// note-on (retrigger > free > steal oldest) or a note-off to the voice bank.
module voice_allocator #(
   parameter int VOICES     = 4,
   parameter int VOICE_BITS = 2,
   parameter int AGE_BITS   = 8
) (
   input  logic                  inCLK,
   input  logic                  inRST,
   voice_allocator_if.slave      ev,
   output logic [VOICES-1:0]     outVoiceGate,
   output logic [VOICES*7-1:0]   outVoiceNote,
   output logic [VOICES-1:0]     outVoiceStart,
   output logic [AGE_BITS-1:0]   outStealCount
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SCAN   = 2'd1,
      S_COMMIT = 2'd2
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [VOICE_BITS-1:0] r_idx;
   logic                  r_on;
   logic [6:0]            r_note;

   logic                  r_mfound;
   logic [VOICE_BITS-1:0] r_midx;
   logic                  r_ffound;
   logic [VOICE_BITS-1:0] r_fidx;
   logic [VOICE_BITS-1:0] r_oidx;
   logic [AGE_BITS-1:0]   r_oage;

   logic [VOICES-1:0]     r_gate;
   logic [VOICES-1:0]     r_start;
   logic [6:0]            r_vnote [VOICES];
   logic [AGE_BITS-1:0]   r_age   [VOICES];
   logic [AGE_BITS-1:0]   r_steal;

   logic                  w_accept;
   logic                  w_last;
   logic                  w_cur_gate;
   logic [6:0]            w_cur_note;
   logic [AGE_BITS-1:0]   w_cur_age;
   logic [VOICE_BITS-1:0] w_tgt;
   logic                  w_steal;

   assign ev.outEventReady = (r_state == S_IDLE);
   assign w_accept   = ev.inEventValid & ev.outEventReady;
   assign w_last     = (r_idx == VOICE_BITS'(VOICES-1));
   assign w_cur_gate = r_gate[r_idx];
   assign w_cur_note = r_vnote[r_idx];
   assign w_cur_age  = r_age[r_idx];

   // Note-on target: retrigger a matching voice, else a free one, else the oldest.
   assign w_steal = ~r_mfound & ~r_ffound;
   assign w_tgt   = r_mfound ? r_midx :
                    r_ffound ? r_fidx : r_oidx;

   // State register.
   always_ff @(posedge inCLK) begin
      if (inRST) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Next-state decode: one scan cycle per voice, then a single commit cycle.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:   if (w_accept) w_next = S_SCAN;
         S_SCAN:   if (w_last)   w_next = S_COMMIT;
         S_COMMIT: w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // Latch the event and track match / free / oldest candidates during the scan.
   always_ff @(posedge inCLK) begin
      if (inRST) begin
         r_idx    <= '0;
         r_on     <= 1'b0;
         r_note   <= '0;
         r_mfound <= 1'b0;
         r_midx   <= '0;
         r_ffound <= 1'b0;
         r_fidx   <= '0;
         r_oidx   <= '0;
         r_oage   <= '0;
      end else begin
         if (r_state == S_IDLE && w_accept) begin
            r_on     <= ev.inEventNoteOn;
            r_note   <= ev.inEventNote;
            r_idx    <= '0;
            r_mfound <= 1'b0;
            r_ffound <= 1'b0;
            r_oidx   <= '0;
            r_oage   <= '0;
         end else if (r_state == S_SCAN) begin
            if (!w_last) r_idx <= r_idx + 1'b1;
            if (!r_mfound && w_cur_gate && w_cur_note == r_note) begin
               r_mfound <= 1'b1;
               r_midx   <= r_idx;
            end
            if (!r_ffound && !w_cur_gate) begin
               r_ffound <= 1'b1;
               r_fidx   <= r_idx;
            end
            // Strictly greater keeps the lowest index on an age tie.
            if (w_cur_age > r_oage) begin
               r_oidx <= r_idx;
               r_oage <= w_cur_age;
            end
         end
      end
   end

   // Voice bank update on the commit edge; start pulses last one cycle.
   always_ff @(posedge inCLK) begin
      if (inRST) begin
         r_gate  <= '0;
         r_start <= '0;
         r_steal <= '0;
         for (int i = 0; i < VOICES; i++) begin
            r_vnote[i] <= '0;
            r_age[i]   <= '0;
         end
      end else begin
         r_start <= '0;
         if (r_state == S_COMMIT) begin
            if (r_on) begin
               for (int i = 0; i < VOICES; i++) begin
                  if (VOICE_BITS'(i) == w_tgt) begin
                     r_gate[i]  <= 1'b1;
                     r_vnote[i] <= r_note;
                     r_age[i]   <= '0;
                     r_start[i] <= 1'b1;
                  end else if (r_age[i] != '1) begin
                     r_age[i] <= r_age[i] + 1'b1;
                  end
               end
               if (w_steal && r_steal != '1)
                  r_steal <= r_steal + 1'b1;
            end else begin
               // Note-off keeps the note so the release tail holds its pitch.
               for (int i = 0; i < VOICES; i++) begin
                  if (r_gate[i] && r_vnote[i] == r_note)
                     r_gate[i] <= 1'b0;
               end
            end
         end
      end
   end

   assign outVoiceGate  = r_gate;
   assign outVoiceStart = r_start;
   assign outStealCount = r_steal;

   for (genvar g = 0; g < VOICES; g++) begin : g_note
      assign outVoiceNote[7*g +: 7] = r_vnote[g];
   end

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: directed scenarios plus randomized events
// checked against a list-based allocation model.
module tb_voice_allocator;
   localparam int V  = 4;
   localparam int VB = 2;
   localparam int AB = 8;
   localparam int AMAX = (1 << AB) - 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   voice_allocator_if ev();

   logic [V-1:0]   gate;
   logic [V-1:0]   start;
   logic [V*7-1:0] notes;
   logic [AB-1:0]  steal;

   voice_allocator #(
      .VOICES(V), .VOICE_BITS(VB), .AGE_BITS(AB)
   ) dut (
      .inCLK(clk),
      .inRST(rst),
      .ev(ev.slave),
      .outVoiceGate(gate),
      .outVoiceNote(notes),
      .outVoiceStart(start),
      .outStealCount(steal)
   );

   int errors = 0;
   int checks = 0;

   int m_gate [V];
   int m_note [V];
   int m_age  [V];
   int m_steal;

   function automatic void m_reset();
      for (int i = 0; i < V; i++) begin
         m_gate[i] = 0; m_note[i] = 0; m_age[i] = 0;
      end
      m_steal = 0;
   endfunction

   // Returns the voice given a start pulse, or -1.
   function automatic int m_apply(bit on, int n);
      int t;
      t = -1;
      if (!on) begin
         for (int i = 0; i < V; i++)
            if (m_gate[i] == 1 && m_note[i] == n) m_gate[i] = 0;
         return -1;
      end
      for (int i = 0; i < V; i++)
         if (t < 0 && m_gate[i] == 1 && m_note[i] == n) t = i;
      if (t < 0)
         for (int i = 0; i < V; i++)
            if (t < 0 && m_gate[i] == 0) t = i;
      if (t < 0) begin
         t = 0;
         for (int i = 1; i < V; i++)
            if (m_age[i] > m_age[t]) t = i;
         if (m_steal < AMAX) m_steal++;
      end
      for (int i = 0; i < V; i++)
         if (i == t) m_age[i] = 0;
         else if (m_age[i] < AMAX) m_age[i]++;
      m_gate[t] = 1;
      m_note[t] = n;
      return t;
   endfunction

   function automatic logic [V-1:0] m_gatev();
      logic [V-1:0] r;
      for (int i = 0; i < V; i++) r[i] = (m_gate[i] == 1);
      return r;
   endfunction

   function automatic logic [V*7-1:0] m_notev();
      logic [V*7-1:0] r;
      for (int i = 0; i < V; i++) r[7*i +: 7] = 7'(m_note[i]);
      return r;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      ev.inEventValid = 1'b0;
      ev.inEventNoteOn = 1'b0;
      ev.inEventNote = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      m_reset();
   endtask

   task automatic send_event(input bit on, input int n,
                             output int lowc,
                             output logic [V-1:0] sv,
                             output int sc);
      int w;
      lowc = 0; sv = '0; sc = 0;
      @(negedge clk);
      ev.inEventValid = 1'b1;
      ev.inEventNoteOn = on;
      ev.inEventNote = 7'(n);
      w = 0;
      while (!ev.outEventReady && w < 50) begin
         @(negedge clk); w++;
      end
      @(negedge clk);
      ev.inEventValid = 1'b0;
      w = 0;
      while (!ev.outEventReady && w < 50) begin
         lowc++;
         sv |= start;
         if (start != '0) sc++;
         @(negedge clk); w++;
      end
      if (w >= 50) begin
         errors++; checks++;
         $display("FAIL ready_timeout: ready=%0b required 1", ev.outEventReady);
      end
      for (int k = 0; k < 2; k++) begin
         sv |= start;
         if (start != '0) sc++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (ev.outEventReady !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: got %0b required 1", ev.outEventReady);
      end
      checks++;
      if ({gate, start, notes, steal} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: gate=%b start=%b notes=%h steal=%0d required all 0",
                  gate, start, notes, steal);
      end
   endtask

   task automatic test_single_note();
      int lc, sc;
      logic [V-1:0] sv;
      do_reset();
      send_event(1'b1, 60, lc, sv, sc);
      void'(m_apply(1'b1, 60));
      checks++;
      if (gate !== 4'b0001) begin
         errors++; $display("FAIL single_gate: got %b required 0001", gate);
      end
      checks++;
      if (notes[6:0] !== 7'd60) begin
         errors++; $display("FAIL single_note: got %0d required 60", notes[6:0]);
      end
      checks++;
      if (sv !== 4'b0001 || sc != 1) begin
         errors++;
         $display("FAIL single_start: got %b x%0d required 0001 x1", sv, sc);
      end
      checks++;
      if (lc != V + 1) begin
         errors++; $display("FAIL single_ready_low: got %0d required %0d", lc, V + 1);
      end
   endtask

   task automatic test_retrigger();
      int lc, sc;
      logic [V-1:0] sv;
      do_reset();
      send_event(1'b1, 60, lc, sv, sc);
      send_event(1'b1, 60, lc, sv, sc);
      checks++;
      if (sv !== 4'b0001 || sc != 1) begin
         errors++;
         $display("FAIL retrig_start: got %b x%0d required 0001 x1", sv, sc);
      end
      checks++;
      if (gate !== 4'b0001) begin
         errors++; $display("FAIL retrig_gate: got %b required 0001", gate);
      end
      checks++;
      if (steal !== 8'd0) begin
         errors++; $display("FAIL retrig_steal: got %0d required 0", steal);
      end
   endtask

   task automatic test_steal();
      int lc, sc;
      int ns [4] = '{60, 62, 64, 67};
      logic [V-1:0] sv;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         send_event(1'b1, ns[k], lc, sv, sc);
         void'(m_apply(1'b1, ns[k]));
      end
      checks++;
      if (gate !== 4'b1111 || notes !== {7'd67, 7'd64, 7'd62, 7'd60}) begin
         errors++;
         $display("FAIL fill_voices: gate=%b notes=%h required 1111 %h",
                  gate, notes, {7'd67, 7'd64, 7'd62, 7'd60});
      end
      send_event(1'b1, 72, lc, sv, sc);
      void'(m_apply(1'b1, 72));
      checks++;
      if (notes[6:0] !== 7'd72 || sv !== 4'b0001) begin
         errors++;
         $display("FAIL steal_target: note0=%0d start=%b required 72 0001",
                  notes[6:0], sv);
      end
      checks++;
      if (steal !== 8'd1) begin
         errors++; $display("FAIL steal_count: got %0d required 1", steal);
      end
   endtask

   task automatic test_note_off();
      int lc, sc;
      logic [V-1:0] sv;
      send_event(1'b0, 62, lc, sv, sc);
      void'(m_apply(1'b0, 62));
      checks++;
      if (gate !== 4'b1101 || notes[13:7] !== 7'd62) begin
         errors++;
         $display("FAIL off_gate: gate=%b note1=%0d required 1101 62",
                  gate, notes[13:7]);
      end
      checks++;
      if (sc != 0 || lc != V + 1) begin
         errors++;
         $display("FAIL off_pulse: starts=%0d low=%0d required 0 %0d", sc, lc, V + 1);
      end
      send_event(1'b1, 65, lc, sv, sc);
      void'(m_apply(1'b1, 65));
      checks++;
      if (sv !== 4'b0010 || notes[13:7] !== 7'd65 || steal !== 8'd1) begin
         errors++;
         $display("FAIL off_reuse: start=%b note1=%0d steal=%0d required 0010 65 1",
                  sv, notes[13:7], steal);
      end
   endtask

   task automatic test_off_nomatch();
      int lc, sc;
      logic [V-1:0] sv;
      logic [V-1:0] g0;
      logic [V*7-1:0] n0;
      int t;
      g0 = m_gatev();
      n0 = m_notev();
      send_event(1'b0, 50, lc, sv, sc);
      void'(m_apply(1'b0, 50));
      checks++;
      if (gate !== g0 || notes !== n0 || sc != 0) begin
         errors++;
         $display("FAIL nomatch: gate=%b notes=%h starts=%0d required %b %h 0",
                  gate, notes, sc, g0, n0);
      end
      send_event(1'b1, 90, lc, sv, sc);
      t = m_apply(1'b1, 90);
      checks++;
      if (sv !== V'(1 << t) || steal !== AB'(m_steal)) begin
         errors++;
         $display("FAIL nomatch_ages: start=%b steal=%0d required %b %0d",
                  sv, steal, V'(1 << t), m_steal);
      end
   endtask

   task automatic test_reset_in_scan();
      @(negedge clk);
      ev.inEventValid = 1'b1;
      ev.inEventNoteOn = 1'b1;
      ev.inEventNote = 7'd70;
      @(negedge clk);
      ev.inEventValid = 1'b0;
      checks++;
      if (ev.outEventReady !== 1'b0) begin
         errors++; $display("FAIL scan_busy: ready=%0b required 0", ev.outEventReady);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      m_reset();
      checks++;
      if (ev.outEventReady !== 1'b1) begin
         errors++; $display("FAIL scan_rst_ready: got %0b required 1", ev.outEventReady);
      end
      checks++;
      if ({gate, start, notes, steal} !== '0) begin
         errors++;
         $display("FAIL scan_rst_outputs: gate=%b start=%b notes=%h steal=%0d required 0",
                  gate, start, notes, steal);
      end
      repeat (V + 3) @(negedge clk);
      checks++;
      if (gate !== '0 || start !== '0) begin
         errors++;
         $display("FAIL scan_rst_dropped: gate=%b start=%b required 0 0", gate, start);
      end
   endtask

   task automatic test_random();
      int lc, sc, t, n;
      bit on;
      logic [V-1:0] sv;
      logic [V-1:0] es;
      do_reset();
      for (int k = 0; k < 300; k++) begin
         on = ($urandom_range(0, 9) < 7);
         n  = $urandom_range(0, 9);
         if ($urandom_range(0, 19) == 0) n = $urandom_range(0, 127);
         send_event(on, n, lc, sv, sc);
         t = m_apply(on, n);
         es = (t >= 0) ? V'(1 << t) : '0;
         checks++;
         if (gate !== m_gatev() || notes !== m_notev()) begin
            errors++;
            $display("FAIL rand_voices[%0d]: gate=%b notes=%h required %b %h",
                     k, gate, notes, m_gatev(), m_notev());
         end
         checks++;
         if (sv !== es || sc != (t >= 0 ? 1 : 0)) begin
            errors++;
            $display("FAIL rand_start[%0d]: got %b x%0d required %b", k, sv, sc, es);
         end
         checks++;
         if (steal !== AB'(m_steal) || lc != V + 1) begin
            errors++;
            $display("FAIL rand_steal[%0d]: steal=%0d low=%0d required %0d %0d",
                     k, steal, lc, m_steal, V + 1);
         end
      end
   endtask

   task automatic test_steal_saturate();
      int lc, sc;
      logic [V-1:0] sv;
      do_reset();
      for (int k = 0; k < 300; k++) begin
         send_event(1'b1, k % 128, lc, sv, sc);
         void'(m_apply(1'b1, k % 128));
      end
      checks++;
      if (steal !== 8'd255) begin
         errors++; $display("FAIL steal_saturate: got %0d required 255", steal);
      end
      checks++;
      if (gate !== m_gatev() || notes !== m_notev()) begin
         errors++;
         $display("FAIL sat_voices: gate=%b notes=%h required %b %h",
                  gate, notes, m_gatev(), m_notev());
      end
   endtask

   initial begin
      rst = 1'b1;
      ev.inEventValid = 1'b0;
      ev.inEventNoteOn = 1'b0;
      ev.inEventNote = '0;
      m_reset();
      test_reset();
      test_single_note();
      test_retrigger();
      test_steal();
      test_note_off();
      test_off_nomatch();
      test_reset_in_scan();
      test_random();
      test_steal_saturate();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
